// File: rtl/lane_scheduler_pkg.sv
// Shared types and constants for the lane scheduler and the lane logic.
package lane_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SETUP,
    STROBE,
    GAP,
    DONE
  } state_e;

  localparam int unsigned CAR_COUNT_MAX = 5;
  localparam int unsigned CAR_SPEED_MAX = 7;
  localparam logic [15:0] LFSR_MASK     = 16'hB400;
  localparam int unsigned CAR_WIDTH     = 48;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/lane_scheduler_lfsr16.sv
// 16-bit Galois LFSR that advances only when Step is high.
module lfsr16
  import lane_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        Step,
  output logic [15:0] State
);

  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] state_q;

  // Advance the sequence on request; only reset reloads it.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= INIT;
    end else if (Step) begin
      state_q <= lfsr_step(state_q);
    end
  end

  assign State = state_q;

endmodule

// File: rtl/lane_scheduler.sv
// Level-start sequencer: generates a pseudo-random configuration per lane,
// drives it onto the shared bus, then strobes each lane's SpawnEnable.
module lane_scheduler
  import lane_pkg::*;
#(
  parameter int unsigned NUM_LANES   = 8,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  input  logic                 Start,
  input  logic                 Abort,
  input  logic [3:0]           Level,
  output logic                 Busy,
  output logic                 Done,
  output logic [NUM_LANES-1:0] SpawnEnable,
  output logic                 Direction,
  output logic [1:0]           CarType,
  output logic [2:0]           CarCount,
  output logic [2:0]           CarSpeed
);

  localparam int unsigned      HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX  = 4'(NUM_LANES - 1);

  state_e        state_q;
  logic [3:0]    idx_q;
  logic [HW-1:0] hold_q;
  logic          done_pend_q;

  logic [15:0]   lfsr;
  logic          step_d;
  logic [4:0]    speed_sum;
  logic [2:0]    speed_d;
  logic [2:0]    count_d;
  logic          unused_bits;

  // Residue of a 3-bit value modulo CAR_COUNT_MAX.
  function automatic logic [2:0] mod5(input logic [2:0] v);
    case (v)
      3'd0:    mod5 = 3'd0;
      3'd1:    mod5 = 3'd1;
      3'd2:    mod5 = 3'd2;
      3'd3:    mod5 = 3'd3;
      3'd4:    mod5 = 3'd4;
      3'd5:    mod5 = 3'd0;
      3'd6:    mod5 = 3'd1;
      default: mod5 = 3'd2;
    endcase
  endfunction

  // The LFSR is stepped on the edge that enters GEN, so during GEN its
  // register already holds the new value and GEN registers the bus from it.
  always_comb begin
    step_d = 1'b0;
    if (!Abort) begin
      step_d = ((state_q == IDLE) && Start) ||
               ((state_q == GAP) && (idx_q != LAST_IDX));
    end
  end

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .Clk    (Clk),
    .ResetN (ResetN),
    .Step   (step_d),
    .State  (lfsr)
  );

  // Configuration fields derived from the current LFSR value.
  always_comb begin
    speed_sum = 5'd1 + {2'b00, Level[3:1]} + {3'b000, lfsr[7:6]};
    speed_d   = (speed_sum > 5'(CAR_SPEED_MAX)) ? 3'(CAR_SPEED_MAX) : speed_sum[2:0];
    count_d   = 3'd1 + mod5(lfsr[5:3]);
  end

  assign unused_bits = ^{Level[0], lfsr[15:8]};

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      hold_q      <= '0;
      done_pend_q <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      SpawnEnable <= '0;
      Direction   <= 1'b0;
      CarType     <= '0;
      CarCount    <= '0;
      CarSpeed    <= '0;
    end else begin
      Done        <= 1'b0;
      done_pend_q <= 1'b0;
      if (Abort) begin
        state_q     <= IDLE;
        Busy        <= 1'b0;
        SpawnEnable <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (Start) begin
              state_q <= GEN;
              idx_q   <= '0;
              Busy    <= 1'b1;
            end
          end
          GEN: begin
            Direction <= lfsr[0];
            CarType   <= lfsr[2:1];
            CarCount  <= count_d;
            CarSpeed  <= speed_d;
            state_q   <= SETUP;
          end
          SETUP: begin
            hold_q      <= '0;
            SpawnEnable <= NUM_LANES'(1) << idx_q;
            state_q     <= STROBE;
          end
          STROBE: begin
            if (hold_q == HOLD_LAST) begin
              SpawnEnable <= '0;
              state_q     <= GAP;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
          GAP: begin
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + 4'd1;
              state_q <= GEN;
            end
          end
          DONE: begin
            // Done is presented on the cycle following the exit from DONE.
            Done    <= 1'b1;
            Busy    <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lane_scheduler.sv
// Randomized bench for lane_scheduler against a timeline/LFSR reference model.
module tb_lane_scheduler;

  localparam int unsigned N    = 8;
  localparam int unsigned H    = 2;
  localparam int          P    = H + 3;
  localparam int          NP   = N * P;
  localparam logic [15:0] SEED = 16'hACE1;

  logic         Clk    = 1'b0;
  logic         ResetN = 1'b0;
  logic         Start  = 1'b0;
  logic         Abort  = 1'b0;
  logic [3:0]   Level  = 4'd0;
  logic         Busy;
  logic         Done;
  logic [N-1:0] SpawnEnable;
  logic         Direction;
  logic [1:0]   CarType;
  logic [2:0]   CarCount;
  logic [2:0]   CarSpeed;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned m_lfsr;
  int unsigned exp_dir, exp_typ, exp_cnt, exp_spd;

  always #5 Clk = ~Clk;

  lane_scheduler #(
    .NUM_LANES   (N),
    .SEED        (SEED),
    .HOLD_CYCLES (H)
  ) dut (
    .Clk         (Clk),
    .ResetN      (ResetN),
    .Start       (Start),
    .Abort       (Abort),
    .Level       (Level),
    .Busy        (Busy),
    .Done        (Done),
    .SpawnEnable (SpawnEnable),
    .Direction   (Direction),
    .CarType     (CarType),
    .CarCount    (CarCount),
    .CarSpeed    (CarSpeed)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned lfsr_next(input int unsigned s);
    return (s % 2 == 1) ? ((s / 2) ^ 32'hB400) : (s / 2);
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"},  Busy, 0);
    check_eq({tag, "_done"},  Done, 0);
    check_eq({tag, "_spawn"}, 32'(SpawnEnable), 0);
    check_eq({tag, "_dir"},   Direction, 0);
    check_eq({tag, "_type"},  CarType, 0);
    check_eq({tag, "_count"}, CarCount, 0);
    check_eq({tag, "_speed"}, CarSpeed, 0);
  endtask

  // One level start; optional Start poke, Abort or reset at step k after the start edge.
  task automatic run_level(input int unsigned lvl, input int poke_k, input int abort_k,
                           input int rst_k, input bit seed_chk);
    int unsigned pd, pt, pc, ps, lane, phase, sp, min_spd;
    pd = 0; pt = 0; pc = 0; ps = 0;
    min_spd = (1 + lvl / 2 > 7) ? 7 : 1 + lvl / 2;
    repeat ($urandom_range(0, 2)) @(negedge Clk);
    Level = 4'(lvl);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    for (int k = 0; k <= NP + 2; k++) begin
      lane  = k / P;
      phase = k % P;
      if (k < NP) begin
        if (phase == 0) begin
          m_lfsr = lfsr_next(m_lfsr);
          pd = m_lfsr % 2;
          pt = (m_lfsr / 2) % 4;
          pc = 1 + ((m_lfsr / 8) % 8) % 5;
          ps = 1 + lvl / 2 + (m_lfsr / 64) % 4;
          if (ps > 7) ps = 7;
        end
        if (phase == 1) begin
          exp_dir = pd; exp_typ = pt; exp_cnt = pc; exp_spd = ps;
        end
        sp = (phase >= 2 && phase <= H + 1) ? (32'd1 << lane) : 0;
        check_eq("busy_run", Busy, 1);
        check_eq("done_run", Done, 0);
      end else begin
        sp = 0;
        check_eq("busy_end", Busy, (k == NP) ? 1 : 0);
        check_eq("done_end", Done, (k == NP + 1) ? 1 : 0);
      end
      check_eq("spawn", 32'(SpawnEnable), sp);
      check_eq("dir",   Direction, exp_dir);
      check_eq("type",  CarType,   exp_typ);
      check_eq("count", CarCount,  exp_cnt);
      check_eq("speed", CarSpeed,  exp_spd);
      if (k >= 1) begin
        check_eq("count_range", (CarCount >= 3'd1 && CarCount <= 3'd5), 1);
        check_eq("speed_range", (32'(CarSpeed) >= min_spd && CarSpeed <= 3'd7), 1);
      end
      if (seed_chk && k == 1) begin
        check_eq("lane0_dir",   Direction, 0);
        check_eq("lane0_type",  CarType,   0);
        check_eq("lane0_count", CarCount,  2);
        check_eq("lane0_speed", CarSpeed,  2);
      end
      if (k == abort_k) begin
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        check_eq("abort_spawn", 32'(SpawnEnable), 0);
        check_eq("abort_busy",  Busy, 0);
        check_eq("abort_done",  Done, 0);
        repeat (P + 2) begin
          @(negedge Clk);
          check_eq("abort_nodone", Done, 0);
          check_eq("abort_idle",   Busy, 0);
        end
        return;
      end
      if (k == rst_k) begin
        #1 ResetN = 1'b0;
        #1 check_all_zero("async_rst");
        m_lfsr  = SEED;
        exp_dir = 0; exp_typ = 0; exp_cnt = 0; exp_spd = 0;
        @(negedge Clk);
        check_all_zero("rst_held");
        ResetN = 1'b1;
        return;
      end
      Start = (k == poke_k);
      @(negedge Clk);
    end
    Start = 1'b0;
  endtask

  initial begin
    m_lfsr  = SEED;
    exp_dir = 0; exp_typ = 0; exp_cnt = 0; exp_spd = 0;
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    ResetN = 1'b1;

    // First level from the default seed at Level 0.
    run_level(0, -1, -1, -1, 1'b1);

    // Highest level, many starts.
    repeat (200) run_level(15, -1, -1, -1, 1'b0);

    // Assorted levels.
    repeat (12) run_level($urandom_range(0, 15), -1, -1, -1, 1'b0);

    // Start while busy (during lane 3) is ignored.
    run_level($urandom_range(0, 15), 3 * P + 1, -1, -1, 1'b0);

    // Start and Abort together in IDLE: stays idle, LFSR untouched.
    @(negedge Clk);
    Start = 1'b1; Abort = 1'b1;
    @(negedge Clk);
    Start = 1'b0; Abort = 1'b0;
    check_eq("start_abort_busy", Busy, 0);
    @(negedge Clk);
    check_eq("start_abort_idle", Busy, 0);
    check_eq("start_abort_done", Done, 0);

    // Abort during the first STROBE cycle of lane 5, then a fresh start.
    run_level($urandom_range(0, 15), -1, 5 * P + 2, -1, 1'b0);
    run_level($urandom_range(0, 15), -1, -1, -1, 1'b0);

    // Reset during the GAP of lane 2, then lane 0 restarts from the seed.
    run_level(0, -1, -1, 2 * P + H + 2, 1'b0);
    run_level(0, -1, -1, -1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
